// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel streaming engine.
package sobel_pkg;

    typedef enum logic {
        NORM_L1  = 1'b0,
        NORM_MAX = 1'b1
    } norm_e;

    localparam int SAT_W = 32;

    // Width of a signed gradient for a given pixel width.
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    // Clamp an unsigned value to the largest value representable in out_w bits.
    function automatic logic [SAT_W-1:0] saturate(input logic [SAT_W-1:0] val,
                                                 input int               out_w);
        logic [SAT_W-1:0] lim;
        lim = (SAT_W'(1) << out_w) - SAT_W'(1);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel kernel: three columns in, signed gx/gy out.
// Column element 0 is the top row, 2 the bottom row.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [2:0][PIX_W-1:0]          col_l,
    input  logic [2:0][PIX_W-1:0]          col_c,
    input  logic [2:0][PIX_W-1:0]          col_r,
    output logic signed [grad_w(PIX_W)-1:0] gx,
    output logic signed [grad_w(PIX_W)-1:0] gy
);

    localparam int GW = grad_w(PIX_W);

    logic [GW-1:0] sum_l, sum_r, sum_t, sum_b;

    // Weighted 1-2-1 sums of the outer columns and outer rows, zero-extended.
    always_comb begin
        sum_l = GW'(col_l[0]) + (GW'(col_l[1]) << 1) + GW'(col_l[2]);
        sum_r = GW'(col_r[0]) + (GW'(col_r[1]) << 1) + GW'(col_r[2]);
        sum_t = GW'(col_l[0]) + (GW'(col_c[0]) << 1) + GW'(col_r[0]);
        sum_b = GW'(col_l[2]) + (GW'(col_c[2]) << 1) + GW'(col_r[2]);
    end

    assign gx = signed'(sum_r - sum_l);
    assign gy = signed'(sum_t - sum_b);

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel edge-magnitude engine. One 3-pixel column per beat, one
// magnitude per column that completes a 3-column window.
// Pipeline: window register -> gradient register -> magnitude register.
// Optional build macro SOBEL_THRESH_EN adds a threshold compare (thresh/out_edge).
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int OUT_W = PIX_W + 3,
    parameter int NORM  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_top,
    input  logic [PIX_W-1:0] in_mid,
    input  logic [PIX_W-1:0] in_bot,
    input  logic             in_sol,
    input  logic             in_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_mag,
    output logic             out_last
`ifdef SOBEL_THRESH_EN
    ,
    input  logic [OUT_W-1:0] thresh,
    output logic             out_edge
`endif
);

    localparam int GW = grad_w(PIX_W);
    localparam int MW = PIX_W + 4;

    typedef logic [2:0][PIX_W-1:0] col_t;

    col_t                 c0, c1, c2, in_col;
    logic [1:0]           col_cnt;
    logic                 w_vld, w_last;
    logic signed [GW-1:0] kx, ky, s1_gx, s1_gy;
    logic                 s1_vld, s1_last;
    logic                 accept, produce, s1_adv, s2_adv;
    logic [GW-1:0]        gx_neg, gy_neg;
    logic [MW-1:0]        ax, ay, comb;
    logic [OUT_W-1:0]     mag_sat;

    assign in_col  = {in_bot, in_mid, in_top};
    assign s2_adv  = !out_valid || out_ready;
    assign s1_adv  = s2_adv || !s1_vld;
    // The window may only be overwritten once a pending window has moved on.
    assign in_ready = !w_vld || s1_adv;
    assign accept   = in_valid && in_ready;
    assign produce  = accept && !in_sol && (col_cnt == 2'd2);

    // Sliding window, column count and the "window holds a result" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0      <= '0;
            c1      <= '0;
            c2      <= '0;
            col_cnt <= 2'd0;
            w_vld   <= 1'b0;
            w_last  <= 1'b0;
        end else begin
            if (accept) begin
                c0     <= c1;
                c1     <= c2;
                c2     <= in_col;
                w_last <= in_eol;
                if (in_sol) begin
                    col_cnt <= 2'd1;
                end else if (col_cnt != 2'd2) begin
                    col_cnt <= col_cnt + 2'd1;
                end
                w_vld <= produce;
            end else if (s1_adv) begin
                w_vld <= 1'b0;
            end
        end
    end

    sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
        .col_l (c0),
        .col_c (c1),
        .col_r (c2),
        .gx    (kx),
        .gy    (ky)
    );

    // Stage 1: register the signed gradients of a completed window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_gx   <= '0;
            s1_gy   <= '0;
            s1_last <= 1'b0;
        end else if (s1_adv) begin
            s1_vld <= w_vld;
            if (w_vld) begin
                s1_gx   <= kx;
                s1_gy   <= ky;
                s1_last <= w_last;
            end
        end
    end

    // Absolute values (each from its own sign), norm combine, saturation.
    always_comb begin
        gx_neg  = -s1_gx;
        gy_neg  = -s1_gy;
        ax      = s1_gx[GW-1] ? MW'(gx_neg) : MW'(unsigned'(s1_gx));
        ay      = s1_gy[GW-1] ? MW'(gy_neg) : MW'(unsigned'(s1_gy));
        comb    = (NORM == int'(NORM_MAX)) ? ((ax > ay) ? ax : ay) : (ax + ay);
        mag_sat = OUT_W'(saturate(SAT_W'(comb), OUT_W));
    end

    // Stage 2: output register; holds its contents while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_last  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_mag  <= mag_sat;
                out_last <= s1_last;
            end
        end
    end

`ifdef SOBEL_THRESH_EN
    // Edge flag registered alongside the magnitude it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_edge <= 1'b0;
        end else if (s2_adv && s1_vld) begin
            out_edge <= (mag_sat >= thresh);
        end
    end
`endif

endmodule
